// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Glyph bits are ordered {g,f,e,d,c,b,a}, 1 = segment lit (before polarity).
package seven_seg_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seven_seg_hex_decoder.sv
// Combinational hex nibble to seven-segment glyph lookup (active-high glyph).
module seven_seg_hex_decoder
  import seven_seg_pkg::*;
(
  input  nibble_t     nibble,
  output logic [6:0]  glyph
);

  assign glyph = GLYPH[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed hex display driver with dead-time slots and frame-synchronous loads.
// Optional build macro LEADING_ZERO_SUPPRESS_EN blanks digits above the top nonzero nibble.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_mask,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW}};
  localparam logic [6:0]        SEG_IDLE = SEG_OFF ^ {7{SEG_ACTIVE_LOW}};

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_value_q, shadow_value_d, active_value_q, active_value_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
  logic [DIGITS-1:0]   shadow_blank_q, shadow_blank_d, active_blank_q, active_blank_d;
  logic                pending_q, pending_d;
  logic                frame_done_q, frame_done_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;

  logic                frame_edge;
  logic [DIGITS-1:0]   blank_eff;
  logic [DIGITS-1:0]   an_sel;
  nibble_t             cur_nibble;
  logic                cur_dp;
  logic                cur_blank;
  logic [6:0]          glyph;

  always_comb begin
    frame_edge = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // A load on the boundary edge bypasses the shadow so it is never a frame late.
  always_comb begin
    shadow_value_d = shadow_value_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;
    active_value_d = active_value_q;
    active_dp_d    = active_dp_q;
    active_blank_d = active_blank_q;
    pending_d      = pending_q;
    if (load) begin
      shadow_value_d = value;
      shadow_dp_d    = dp_in;
      shadow_blank_d = blank_mask;
    end
    if (frame_edge) begin
      if (load) begin
        active_value_d = value;
        active_dp_d    = dp_in;
        active_blank_d = blank_mask;
      end else if (pending_q) begin
        active_value_d = shadow_value_q;
        active_dp_d    = shadow_dp_q;
        active_blank_d = shadow_blank_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

`ifdef LEADING_ZERO_SUPPRESS_EN
  logic lzs_run;

  // Walk down from the top digit; digit 0 is never suppressed.
  always_comb begin
    blank_eff = active_blank_q;
    lzs_run   = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if ((active_value_q[4*k +: 4] != 4'h0) || active_dp_q[k]) lzs_run = 1'b0;
      if (lzs_run) blank_eff[k] = 1'b1;
    end
  end
`else
  assign blank_eff = active_blank_q;
`endif

  always_comb begin
    cur_nibble = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    an_sel     = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nibble = active_value_q[4*k +: 4];
        cur_dp     = active_dp_q[k];
        cur_blank  = blank_eff[k];
        an_sel[k]  = 1'b1;
      end
    end
  end

  seven_seg_hex_decoder u_decoder (
    .nibble (cur_nibble),
    .glyph  (glyph)
  );

  // Slot cycle 0 is dead time so the previous digit's segments cannot ghost.
  always_comb begin
    an_d         = AN_OFF;
    seg_d        = SEG_IDLE;
    dp_d         = SEG_ACTIVE_LOW;
    frame_done_d = frame_edge;
    if (cnt_q != '0) begin
      an_d = an_sel ^ AN_OFF;
      if (!cur_blank) begin
        seg_d = glyph ^ {7{SEG_ACTIVE_LOW}};
        dp_d  = cur_dp ^ SEG_ACTIVE_LOW;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      shadow_value_q <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      active_value_q <= '0;
      active_dp_q    <= '0;
      active_blank_q <= '0;
      pending_q      <= 1'b0;
      frame_done_q   <= 1'b0;
      an_q           <= AN_OFF;
      seg_q          <= SEG_IDLE;
      dp_q           <= SEG_ACTIVE_LOW;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      shadow_value_q <= shadow_value_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      active_value_q <= active_value_d;
      active_dp_q    <= active_dp_d;
      active_blank_q <= active_blank_d;
      pending_q      <= pending_d;
      frame_done_q   <= frame_done_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule
